// File: rtl/uart_ip_rx.sv
// UART receive engine: oversampled start/data/parity/stop deserialiser with
// a single-entry holding register and parity, framing and overrun flags.
module uart_ip_rx #(
    parameter int CLK_HZ = 100_000_000,
    parameter int OSR    = 16
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       rx,
    input  logic       en,
    input  logic [1:0] frame_size,
    input  logic [1:0] parity_cfg,
    input  logic       stop_bits,
    input  logic [3:0] baud_sel,
    input  logic       rd_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int TW = $clog2(OSR);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    state_t      state, state_next;
    logic        rx_meta, rxs, rxs_prev;
    logic [31:0] div_cnt, div_m1;
    logic [TW-1:0] tick_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg, frame_data;
    logic [1:0]  cfg_size, cfg_par;
    logic        cfg_stop;
    logic [3:0]  cfg_baud;
    logic        par_bad, stop_bad, done;
    logic        tick, tick_half, tick_last, par_en;
    logic        go_start, tick_clr, shift_en, par_sample, stop_sample, finish;

    function automatic logic [31:0] div_m1_for(input int baud);
        int d;
        d = CLK_HZ / (OSR * baud);
        if (d < 1) d = 1;
        return 32'(d - 1);
    endfunction

    always_comb begin
        div_m1 = div_m1_for(115200);
        case (cfg_baud)
            4'd0:    div_m1 = div_m1_for(300);
            4'd1:    div_m1 = div_m1_for(600);
            4'd2:    div_m1 = div_m1_for(1200);
            4'd3:    div_m1 = div_m1_for(2400);
            4'd4:    div_m1 = div_m1_for(4800);
            4'd5:    div_m1 = div_m1_for(9600);
            4'd6:    div_m1 = div_m1_for(14400);
            4'd7:    div_m1 = div_m1_for(19200);
            4'd8:    div_m1 = div_m1_for(38400);
            4'd9:    div_m1 = div_m1_for(57600);
            4'd10:   div_m1 = div_m1_for(115200);
            4'd11:   div_m1 = div_m1_for(230400);
            4'd12:   div_m1 = div_m1_for(460800);
            4'd13:   div_m1 = div_m1_for(921600);
            default: div_m1 = div_m1_for(115200);
        endcase
    end

    assign tick       = (state != IDLE) && (div_cnt == div_m1);
    assign tick_half  = tick && (tick_cnt == TW'(OSR / 2 - 1));
    assign tick_last  = tick && (tick_cnt == TW'(OSR - 1));
    assign par_en     = (cfg_par == 2'b01) || (cfg_par == 2'b10);
    // Bits arrive LSB first into the top of shreg, so short frames need right-aligning.
    assign frame_data = shreg >> (2'd3 - cfg_size);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta  <= rx;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next  = state;
        go_start    = 1'b0;
        tick_clr    = 1'b0;
        shift_en    = 1'b0;
        par_sample  = 1'b0;
        stop_sample = 1'b0;
        finish      = 1'b0;
        if (!en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (rxs_prev && !rxs) begin
                    go_start   = 1'b1;
                    state_next = START;
                end
                START: if (tick_half) begin
                    tick_clr   = 1'b1;
                    state_next = rxs ? IDLE : DATA;
                end
                DATA: if (tick_last) begin
                    tick_clr = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == 3'd4 + {1'b0, cfg_size})
                        state_next = par_en ? PARITY : STOP1;
                end
                PARITY: if (tick_last) begin
                    tick_clr   = 1'b1;
                    par_sample = 1'b1;
                    state_next = STOP1;
                end
                STOP1: if (tick_last) begin
                    tick_clr    = 1'b1;
                    stop_sample = 1'b1;
                    if (cfg_stop) begin
                        state_next = STOP2;
                    end else begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end
                end
                STOP2: if (tick_last) begin
                    tick_clr    = 1'b1;
                    stop_sample = 1'b1;
                    finish      = 1'b1;
                    state_next  = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath counters and frame capture; everything restarts on a new start edge.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            cfg_size <= '0;
            cfg_par  <= '0;
            cfg_stop <= 1'b0;
            cfg_baud <= '0;
            par_bad  <= 1'b0;
            stop_bad <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= finish;
            if (go_start) begin
                div_cnt  <= '0;
                tick_cnt <= '0;
                bit_idx  <= '0;
                shreg    <= '0;
                cfg_size <= frame_size;
                cfg_par  <= parity_cfg;
                cfg_stop <= stop_bits;
                cfg_baud <= baud_sel;
                par_bad  <= 1'b0;
                stop_bad <= 1'b0;
            end else if (state != IDLE) begin
                div_cnt <= (div_cnt == div_m1) ? '0 : div_cnt + 32'd1;
                if (tick_clr)  tick_cnt <= '0;
                else if (tick) tick_cnt <= tick_cnt + 1'b1;
                if (shift_en) begin
                    shreg   <= {rxs, shreg[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                end
                // Unused shreg bits are zero, so reducing all 8 gives the data parity.
                if (par_sample)
                    par_bad <= (^shreg) ^ rxs ^ (cfg_par == 2'b10);
                if (stop_sample && !rxs)
                    stop_bad <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (done) begin
            if (!rx_valid || rd_ack) begin
                rx_data    <= frame_data;
                parity_err <= par_bad;
                frame_err  <= stop_bad;
                rx_valid   <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (rd_ack && rx_valid) begin
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_ip_rx.sv
// Directed bench for uart_ip_rx: hand-built frames on rx, held byte and flags
// compared against hand-computed values.
module tb_uart_ip_rx;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       rx = 1'b1;
    logic       en = 1'b0;
    logic [1:0] frame_size = 2'b11;
    logic [1:0] parity_cfg = 2'b00;
    logic       stop_bits = 1'b0;
    logic [3:0] baud_sel = 4'd10;
    logic       rd_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, parity_err, frame_err, overrun, busy;

    int n_checks = 0;
    int n_fail = 0;
    int bit_clks = 864;

    always #5 clk = ~clk;

    uart_ip_rx #(.CLK_HZ(100_000_000), .OSR(16)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .rx         (rx),
        .en         (en),
        .frame_size (frame_size),
        .parity_cfg (parity_cfg),
        .stop_bits  (stop_bits),
        .baud_sel   (baud_sel),
        .rd_ack     (rd_ack),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic waitClks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one whole frame starting at the current negedge, then idle_val for one bit.
    task automatic applyStimulus(input logic [7:0] data, input int nbits, input bit has_par,
                                 input logic par_bit, input int nstop, input logic stop_val,
                                 input logic idle_val);
        logic [7:0] d;
        d = data;
        rx = 1'b0;
        waitClks(bit_clks);
        for (int i = 0; i < nbits; i++) begin
            rx = d[i];
            waitClks(bit_clks);
        end
        if (has_par) begin
            rx = par_bit;
            waitClks(bit_clks);
        end
        for (int i = 0; i < nstop; i++) begin
            rx = stop_val;
            waitClks(bit_clks);
        end
        rx = idle_val;
        waitClks(bit_clks);
    endtask

    task automatic pulseAck();
        rd_ack = 1'b1;
        waitClks(1);
        rd_ack = 1'b0;
        waitClks(1);
    endtask

    task automatic checkHeld(input string tag, input logic [7:0] d, input logic pe,
                             input logic fe, input logic ov);
        checkOutput({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
        checkOutput({tag, "_data"}, {24'd0, rx_data}, {24'd0, d});
        checkOutput({tag, "_perr"}, {31'd0, parity_err}, {31'd0, pe});
        checkOutput({tag, "_ferr"}, {31'd0, frame_err}, {31'd0, fe});
        checkOutput({tag, "_ovr"}, {31'd0, overrun}, {31'd0, ov});
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, "_valid"}, {31'd0, rx_valid}, 32'd0);
        checkOutput({tag, "_perr"}, {31'd0, parity_err}, 32'd0);
        checkOutput({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
        checkOutput({tag, "_ovr"}, {31'd0, overrun}, 32'd0);
    endtask

    initial begin
        waitClks(3);
        checkCleared("reset");
        checkOutput("reset_data", {24'd0, rx_data}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        arst_n = 1'b1;
        en = 1'b1;
        waitClks(5);

        $display("[TB] 8N1 at 115200");
        applyStimulus(8'hA5, 8, 0, 1'b0, 1, 1'b1, 1'b1);
        checkHeld("a5", 8'hA5, 1'b0, 1'b0, 1'b0);
        pulseAck();
        checkCleared("a5_ack");

        baud_sel = 4'd15;
        applyStimulus(8'h96, 8, 0, 1'b0, 1, 1'b1, 1'b1);
        checkHeld("sel15", 8'h96, 1'b0, 1'b0, 1'b0);
        pulseAck();

        // Remaining frames at 921600: DIV=6, one bit = 96 clks
        baud_sel = 4'd13;
        bit_clks = 96;

        $display("[TB] 5-bit parity frames");
        frame_size = 2'b00; parity_cfg = 2'b01; stop_bits = 1'b1;
        applyStimulus(8'h15, 5, 1, 1'b1, 2, 1'b1, 1'b1);
        checkHeld("e2_p1", 8'h15, 1'b0, 1'b0, 1'b0);
        pulseAck();
        applyStimulus(8'h15, 5, 1, 1'b0, 2, 1'b1, 1'b1);
        checkHeld("e2_p0", 8'h15, 1'b1, 1'b0, 1'b0);
        pulseAck();
        checkCleared("e2_ack");
        parity_cfg = 2'b10; stop_bits = 1'b0;
        applyStimulus(8'h15, 5, 1, 1'b0, 1, 1'b1, 1'b1);
        checkHeld("o1_p0", 8'h15, 1'b0, 1'b0, 1'b0);
        pulseAck();
        applyStimulus(8'h15, 5, 1, 1'b1, 1, 1'b1, 1'b1);
        checkHeld("o1_p1", 8'h15, 1'b1, 1'b0, 1'b0);
        pulseAck();

        $display("[TB] framing error and break");
        frame_size = 2'b11; parity_cfg = 2'b00; stop_bits = 1'b0;
        applyStimulus(8'h3C, 8, 0, 1'b0, 1, 1'b0, 1'b0);
        checkHeld("brk", 8'h3C, 1'b0, 1'b1, 1'b0);
        waitClks(3 * bit_clks);
        checkOutput("brk_busy", {31'd0, busy}, 32'd0);
        pulseAck();
        rx = 1'b1;
        waitClks(bit_clks);
        applyStimulus(8'h5A, 8, 0, 1'b0, 1, 1'b1, 1'b1);
        checkHeld("after_brk", 8'h5A, 1'b0, 1'b0, 1'b0);
        pulseAck();

        $display("[TB] overrun");
        applyStimulus(8'h11, 8, 0, 1'b0, 1, 1'b1, 1'b1);
        applyStimulus(8'h22, 8, 0, 1'b0, 1, 1'b1, 1'b1);
        checkHeld("ovr", 8'h11, 1'b0, 1'b0, 1'b1);
        pulseAck();
        checkCleared("ovr_ack");

        // Final stop sample lands 915 clks after the start edge is driven; load is one clk later.
        applyStimulus(8'h33, 8, 0, 1'b0, 1, 1'b1, 1'b1);
        checkHeld("c33", 8'h33, 1'b0, 1'b0, 1'b0);
        fork
            applyStimulus(8'h22, 8, 0, 1'b0, 1, 1'b1, 1'b1);
            begin
                waitClks(915);
                rd_ack = 1'b1;
                waitClks(1);
                rd_ack = 1'b0;
            end
        join
        checkHeld("coinc", 8'h22, 1'b0, 1'b0, 1'b0);
        pulseAck();

        $display("[TB] config latched at start");
        fork
            applyStimulus(8'hC3, 8, 0, 1'b0, 1, 1'b1, 1'b1);
            begin
                waitClks(200);
                frame_size = 2'b00; parity_cfg = 2'b01; stop_bits = 1'b1;
            end
        join
        checkHeld("latch", 8'hC3, 1'b0, 1'b0, 1'b0);
        frame_size = 2'b11; parity_cfg = 2'b00; stop_bits = 1'b0;
        pulseAck();

        $display("[TB] glitch, disable and reset aborts");
        baud_sel = 4'd10;
        rx = 1'b0;
        waitClks(100);
        checkOutput("glitch_busy1", {31'd0, busy}, 32'd1);
        waitClks(200);
        rx = 1'b1;
        waitClks(1000);
        checkOutput("glitch_busy0", {31'd0, busy}, 32'd0);
        checkOutput("glitch_valid", {31'd0, rx_valid}, 32'd0);
        baud_sel = 4'd13;

        rx = 1'b0;
        waitClks(96);
        rx = 1'b1;
        waitClks(200);
        checkOutput("en_busy1", {31'd0, busy}, 32'd1);
        en = 1'b0;
        waitClks(1);
        checkOutput("en_busy0", {31'd0, busy}, 32'd0);
        waitClks(1200);
        en = 1'b1;
        waitClks(50);
        checkOutput("en_valid", {31'd0, rx_valid}, 32'd0);

        rx = 1'b0;
        waitClks(200);
        checkOutput("rst_busy1", {31'd0, busy}, 32'd1);
        arst_n = 1'b0;
        #1;
        checkOutput("rst_busy0", {31'd0, busy}, 32'd0);
        rx = 1'b1;
        waitClks(5);
        arst_n = 1'b1;
        waitClks(1200);
        checkOutput("rst_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("rst_idle", {31'd0, busy}, 32'd0);
        applyStimulus(8'h7E, 8, 0, 1'b0, 1, 1'b1, 1'b1);
        checkHeld("post_rst", 8'h7E, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
